// File: rtl/v_instr_issue_queue_if.sv
// Decoder-side and dispatcher-side handshake bundle for the vector instruction issue queue.
interface v_instr_issue_queue_if #(
  parameter int INSTR_W = 128
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               req;
  logic [INSTR_W-1:0] out_instr;
  logic               ack;

  modport master (
    output in_valid, in_instr, ack,
    input  in_ready, req, out_instr
  );

  modport slave (
    input  in_valid, in_instr, ack,
    output in_ready, req, out_instr
  );
endinterface

// File: rtl/v_instr_issue_queue.sv
// Circular issue queue between vector decoder and dispatcher: one-cycle req pulse per head entry,
// bounded ack window, retry on expiry with a saturating retry counter.
module v_instr_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int INSTR_W  = 128,
  parameter int ACK_WAIT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  v_instr_issue_queue_if.slave     bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               retry_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [7:0]         retry_q, retry_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];

  logic full, push, pop, expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      retry_q     <= '0;
      out_instr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      retry_q     <= retry_d;
      out_instr_q <= out_instr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Flush overrides everything; a push while full is refused even if a pop lands the same cycle.
  always_comb begin
    full   = (count_q == CW'(DEPTH));
    push   = bus.in_valid & ~full & ~flush;
    pop    = (state_q == WAIT) & bus.ack & ~flush;
    expire = (state_q == WAIT) & ~bus.ack & ~flush & (wait_q == WW'(ACK_WAIT - 1));

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.in_instr;

    rd_ptr_d = flush ? '0 : (pop  ? rd_ptr_q + PW'(1) : rd_ptr_q);
    wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + PW'(1) : wr_ptr_q);

    count_d = count_q;
    if (flush)              count_d = '0;
    else if (push && !pop)  count_d = count_q + CW'(1);
    else if (pop && !push)  count_d = count_q - CW'(1);

    // mem_d already holds a same-cycle push, so a pop of the last entry picks it up directly.
    out_instr_d = out_instr_q;
    if (flush)                        out_instr_d = mem_q[0];
    else if (pop)                     out_instr_d = mem_d[rd_ptr_q + PW'(1)];
    else if (push && count_q == '0)   out_instr_d = bus.in_instr;

    retry_d = (expire && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (flush) begin
      state_d = IDLE;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (count_d != '0) state_d = REQ;
        REQ: begin
          state_d = WAIT;
          wait_d  = '0;
        end
        WAIT: begin
          if (pop)         state_d = (count_d != '0) ? REQ : IDLE;
          else if (expire) state_d = REQ;
          else             wait_d  = wait_q + WW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req       = (state_q == REQ);
    bus.in_ready  = ~full;
    bus.out_instr = out_instr_q;
    count         = count_q;
    retry_cnt     = retry_q;
  end
endmodule
